// File: rtl/mac_psum_post_pkg.sv
// Shared definitions for the MAC partial-sum post-processing stage:
// default widths, FSM state encoding, saturation limits and the
// accumulator-width helper.
package mac_psum_post_pkg;

    localparam int DATA_BIT_DEF = 16;
    localparam int ACC_BIT_DEF  = 2 * DATA_BIT_DEF + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        POST = 2'd2
    } state_t;

    // Accumulating num_ch values of acc_bit bits needs clog2(num_ch) extra
    // bits, plus one guard bit so the bias/rounding add cannot wrap.
    function automatic int acc_width(input int acc_bit, input int num_ch);
        return acc_bit + $clog2(num_ch) + 1;
    endfunction

    // Largest positive value representable in data_bit signed bits.
    function automatic longint sat_pos(input int data_bit);
        return (64'sd1 <<< (data_bit - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in data_bit signed bits.
    function automatic longint sat_neg(input int data_bit);
        return -(64'sd1 <<< (data_bit - 1));
    endfunction

endpackage

// File: rtl/mac_psum_post_fifo.sv
// psum_out_fifo: small synchronous FIFO with a registered head word.
// dout always presents the oldest entry and holds its last value when
// the FIFO runs empty. flush empties the FIFO on the next clock edge and
// takes priority over push and pop. DEPTH must be a power of two >= 2.
module psum_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_eff;
    logic             push_eff;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count == CNT_W'(DEPTH - 1));
    assign pop_eff     = pop && !empty;
    assign push_eff    = push && (!full || pop_eff);

    // Storage array write port.
    // NOTE: the storage array has no reset; contents are only ever read
    // behind a valid count, so resetting it would just cost flops and muxes.
    always_ff @(posedge clk) begin
        if (push_eff && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // The head only changes when the oldest entry changes: a push
            // into an empty FIFO, or a pop exposing the next entry (which is
            // the incoming word when only one entry was stored).
            if (empty && push_eff) begin
                dout <= din;
            end else if (pop_eff && (count > CNT_W'(1))) begin
                dout <= mem[rd_ptr + PTR_W'(1)];
            end else if (pop_eff && push_eff) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/mac_psum_post.sv
// mac_psum_post: accumulates NUM_CH signed partial sums from the 3-tap
// MAC, adds a bias aligned to the accumulator scale, rounds, shifts right
// by SHIFT and clamps to DATA_BIT bits, then queues the result in a small
// output FIFO. Requantized results pass through one register stage before
// entering the FIFO, so the first output appears two cycles after the
// last partial sum of a group is accepted.
// Build option: define PSUM_RELU_EN to clamp negative results to zero
// (ReLU) instead of saturating them to the negative limit.
module mac_psum_post
    import mac_psum_post_pkg::*;
#(
    parameter int DATA_BIT   = DATA_BIT_DEF,
    parameter int ACC_BIT    = 2 * DATA_BIT + 2,
    parameter int NUM_CH     = 4,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       psum_valid,
    output logic                       psum_ready,
    input  logic signed [ACC_BIT-1:0]  psum_in,
    input  logic                       bias_we,
    input  logic signed [DATA_BIT-1:0] bias_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_BIT-1:0]        out_data,
    output logic                       busy,
    output logic                       sat_flag
);

    localparam int ACC_W = acc_width(ACC_BIT, NUM_CH);
    localparam int BSH_W = DATA_BIT + SHIFT;
    // Post-processing width: wide enough for the accumulator, the shifted
    // bias and the rounding constant without any wrap.
    localparam int T_W   = ((ACC_W > BSH_W) ? ACC_W : BSH_W) + 2;
    localparam int CNT_W = $clog2(NUM_CH) + 1;

    localparam logic signed [T_W-1:0] RND     = T_W'(1) <<< (SHIFT - 1);
    localparam logic signed [T_W-1:0] POS_LIM = T_W'(sat_pos(DATA_BIT));
    localparam logic [DATA_BIT-1:0]   POS_Q   = {1'b0, {(DATA_BIT-1){1'b1}}};
`ifndef PSUM_RELU_EN
    localparam logic signed [T_W-1:0] NEG_LIM = T_W'(sat_neg(DATA_BIT));
    localparam logic [DATA_BIT-1:0]   NEG_Q   = {1'b1, {(DATA_BIT-1){1'b0}}};
`endif

    state_t                     state;
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           ch_cnt;
    logic signed [DATA_BIT-1:0] bias;
    logic                       run;
    logic                       res_valid;
    logic [DATA_BIT-1:0]        res_data;

    logic                       accept;
    logic                       no_room;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_almost_full;

    logic signed [T_W-1:0]      t_sum;
    logic signed [T_W-1:0]      r_shift;
    logic [DATA_BIT-1:0]        q_data;
    logic                       q_clip;

    // A result sitting in the stage register is already committed to the
    // FIFO, so it counts against the free space when accepting new input.
    assign no_room    = fifo_full || (res_valid && fifo_almost_full);
    assign psum_ready = run && (state != POST) && !no_room;
    assign accept     = psum_valid && psum_ready;
    assign out_valid  = !fifo_empty;
    assign busy       = (state != IDLE) || res_valid || !fifo_empty;

    // Bias register: survives clear, only reset or a write changes it.
    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias <= '0;
        end else if (bias_we) begin
            bias <= bias_in;
        end
    end

    // Round, shift and clamp the finished accumulation.
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        t_sum   = T_W'(acc) + (T_W'(bias) <<< SHIFT) + RND;
        r_shift = t_sum >>> SHIFT;
        q_data  = r_shift[DATA_BIT-1:0];
        q_clip  = 1'b0;
`ifdef PSUM_RELU_EN
        if (r_shift < 0) begin
            q_data = '0;
        end else if (r_shift > POS_LIM) begin
            q_data = POS_Q;
            q_clip = 1'b1;
        end
`else
        if (r_shift > POS_LIM) begin
            q_data = POS_Q;
            q_clip = 1'b1;
        end else if (r_shift < NEG_LIM) begin
            q_data = NEG_Q;
            q_clip = 1'b1;
        end
`endif
    end

    // Accumulation FSM, result stage register and sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ch_cnt    <= '0;
            run       <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            run       <= 1'b1;
            res_valid <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                acc      <= '0;
                ch_cnt   <= '0;
                sat_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            acc    <= ACC_W'(psum_in);
                            ch_cnt <= CNT_W'(1);
                            state  <= (NUM_CH == 1) ? POST : ACC;
                        end
                    end
                    ACC: begin
                        if (accept) begin
                            acc    <= acc + ACC_W'(psum_in);
                            ch_cnt <= ch_cnt + CNT_W'(1);
                            if (ch_cnt == CNT_W'(NUM_CH - 1)) begin
                                state <= POST;
                            end
                        end
                    end
                    POST: begin
                        res_data  <= q_data;
                        res_valid <= 1'b1;
                        if (q_clip) begin
                            sat_flag <= 1'b1;
                        end
                        acc    <= '0;
                        ch_cnt <= '0;
                        state  <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    psum_out_fifo #(
        .WIDTH (DATA_BIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (clear),
        .push        (res_valid),
        .din         (res_data),
        .pop         (out_ready),
        .dout        (out_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almost_full (fifo_almost_full)
    );

endmodule

// File: tb/tb_mac_psum_post.sv
// Self-checking bench for mac_psum_post (DATA_BIT=16, NUM_CH=4, SHIFT=8,
// FIFO_DEPTH=4). Expected results are queued when a group is driven and
// compared by a monitor whenever the DUT hands over an output word.
module tb_mac_psum_post;

    localparam int DATA_BIT   = 16;
    localparam int ACC_BIT    = 2 * DATA_BIT + 2;
    localparam int NUM_CH     = 4;
    localparam int SHIFT      = 8;
    localparam int FIFO_DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       clear = 1'b0;
    logic                       psum_valid = 1'b0;
    logic                       psum_ready;
    logic signed [ACC_BIT-1:0]  psum_in = '0;
    logic                       bias_we = 1'b0;
    logic signed [DATA_BIT-1:0] bias_in = '0;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic [DATA_BIT-1:0]        out_data;
    logic                       busy;
    logic                       sat_flag;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int out_seen  = 0;
    logic [DATA_BIT-1:0] exp_q[$];
    logic [DATA_BIT-1:0] mon_exp;
    bit sender_done;

    mac_psum_post #(
        .DATA_BIT   (DATA_BIT),
        .ACC_BIT    (ACC_BIT),
        .NUM_CH     (NUM_CH),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_in    (psum_in),
        .bias_we    (bias_we),
        .bias_in    (bias_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: a word is handed over on the edge after this
    // negedge whenever out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total_cnt++;
            out_seen++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: got %0d, required no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    $display("FAIL out_data: got %0d, required %0d", out_data, mon_exp);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    // Reference requantization: round half up, floor shift, clamp.
    function automatic logic [DATA_BIT-1:0] model(input longint sum, input longint b);
        longint t;
        longint r;
        longint pos;
        longint neg;
        pos = (64'sd1 <<< (DATA_BIT - 1)) - 1;
        neg = -(64'sd1 <<< (DATA_BIT - 1));
        t = sum + (b <<< SHIFT) + (64'sd1 <<< (SHIFT - 1));
        r = t >>> SHIFT;
`ifdef PSUM_RELU_EN
        if (r < 0) r = 0;
`else
        if (r < neg) r = neg;
`endif
        if (r > pos) r = pos;
        return DATA_BIT'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bias(input longint v);
        bias_we = 1'b1;
        bias_in = DATA_BIT'(v);
        tick();
        bias_we = 1'b0;
    endtask

    // Present one partial sum until it is accepted; returns #1 after the
    // accepting edge.
    task automatic send_psum(input longint v, output bit ok);
        logic rdy;
        ok = 1'b0;
        psum_valid = 1'b1;
        psum_in = ACC_BIT'(v);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            rdy = psum_ready;
            tick();
            if (rdy) ok = 1'b1;
        end
        psum_valid = 1'b0;
        if (!ok) begin
            total_cnt++;
            $display("FAIL psum_accept: value %0d not accepted within 300 cycles, required acceptance", v);
        end
    endtask

    task automatic send_group(input longint p0, input longint p1, input longint p2,
                              input longint p3, input logic [DATA_BIT-1:0] expv);
        bit ok;
        exp_q.push_back(expv);
        send_psum(p0, ok);
        send_psum(p1, ok);
        send_psum(p2, ok);
        send_psum(p3, ok);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        total_cnt++;
        if (exp_q.size() != 0 || busy) begin
            $display("FAIL %s_drain: pending=%0d busy=%0b, required pending=0 busy=0", name, exp_q.size(), busy);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total_cnt++;
        if ({psum_ready, out_valid, busy, sat_flag} !== 4'b0000 || out_data !== '0) begin
            $display("FAIL reset_outputs: got ready=%0b valid=%0b busy=%0b sat=%0b data=%0d, required all 0",
                     psum_ready, out_valid, busy, sat_flag, out_data);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (psum_ready !== 1'b0) $display("FAIL reset_release_ready: got %0b, required 0 before first clock", psum_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (psum_ready !== 1'b1) $display("FAIL reset_first_clock_ready: got %0b, required 1", psum_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_group(256, 512, 768, 1024, 16'd10);
        // Now #1 after the 4th accept edge: the POST cycle.
        total_cnt++;
        if (psum_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL basic_post_cycle: got ready=%0b valid=%0b, required 0 0", psum_ready, out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (psum_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL basic_after_post: got ready=%0b valid=%0b, required 1 0", psum_ready, out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'd10)
            $display("FAIL basic_latency: got valid=%0b data=%0d, required 1 10", out_valid, out_data);
        else pass_cnt++;
        wait_drain("basic");
    endtask

    task automatic test_rounding();
        send_group(384, 0, 0, 0, 16'd2);
        send_group(383, 0, 0, 0, 16'd1);
        set_bias(3);
        send_group(0, 0, 0, 0, 16'd3);
        wait_drain("rounding");
        set_bias(0);
    endtask

    task automatic test_negative();
`ifdef PSUM_RELU_EN
        send_group(-1000, 0, 0, 0, 16'd0);
`else
        send_group(-1000, 0, 0, 0, 16'hFFFC);
`endif
        wait_drain("negative");
        total_cnt++;
        if (sat_flag !== 1'b0) $display("FAIL negative_sat: got %0b, required 0", sat_flag);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        send_group(64'sd1 <<< 30, 0, 0, 0, 16'd32767);
        wait_drain("sat_pos");
        total_cnt++;
        if (sat_flag !== 1'b1) $display("FAIL sat_set: got %0b, required 1", sat_flag);
        else pass_cnt++;
        send_group(256, 0, 0, 0, 16'd1);
        wait_drain("sat_hold");
        total_cnt++;
        if (sat_flag !== 1'b1) $display("FAIL sat_sticky: got %0b, required 1", sat_flag);
        else pass_cnt++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total_cnt++;
        if (sat_flag !== 1'b0) $display("FAIL sat_clear: got %0b, required 0", sat_flag);
        else pass_cnt++;
`ifdef PSUM_RELU_EN
        send_group(-(64'sd1 <<< 32), 0, 0, 0, 16'd0);
`else
        send_group(-(64'sd1 <<< 32), 0, 0, 0, 16'h8000);
`endif
        wait_drain("sat_neg");
        total_cnt++;
`ifdef PSUM_RELU_EN
        if (sat_flag !== 1'b0) $display("FAIL sat_neg_flag: got %0b, required 0", sat_flag);
`else
        if (sat_flag !== 1'b1) $display("FAIL sat_neg_flag: got %0b, required 1", sat_flag);
`endif
        else pass_cnt++;
    endtask

    task automatic test_random();
        longint p[4];
        longint b;
        for (int g = 0; g < 6; g++) begin
            b = longint'($urandom_range(0, 400)) - 200;
            set_bias(b);
            for (int k = 0; k < 4; k++) begin
                if (g < 3) p[k] = longint'($urandom_range(0, 1 << 21)) - (64'sd1 <<< 20);
                else       p[k] = longint'($urandom_range(0, 1 << 27)) - (64'sd1 <<< 26);
            end
            send_group(p[0], p[1], p[2], p[3], model(p[0] + p[1] + p[2] + p[3], b));
        end
        wait_drain("random");
        set_bias(0);
    endtask

    task automatic test_back_to_back();
        int seen0;
        int n;
        out_ready = 1'b0;
        seen0 = out_seen;
        sender_done = 1'b0;
        fork
            begin
                for (int g = 0; g < 5; g++) begin
                    send_group(longint'((g + 1) * 2560), 0, 0, 0, 16'((g + 1) * 10));
                end
                sender_done = 1'b1;
            end
        join_none
        repeat (60) tick();
        @(negedge clk);
        total_cnt++;
        if (psum_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd10 || out_seen != seen0)
            $display("FAIL backpressure_full: got ready=%0b valid=%0b head=%0d popped=%0d, required 0 1 10 0",
                     psum_ready, out_valid, out_data, out_seen - seen0);
        else pass_cnt++;
        tick();
        out_ready = 1'b1;
        n = 0;
        while (!sender_done && n < 400) begin
            tick();
            n++;
        end
        total_cnt++;
        if (!sender_done) $display("FAIL backpressure_sender: got stalled, required all groups accepted");
        else pass_cnt++;
        wait_drain("backpressure");
        total_cnt++;
        if (out_seen - seen0 != 5) $display("FAIL backpressure_count: got %0d outputs, required 5", out_seen - seen0);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        bit ok;
        set_bias(2);
        out_ready = 1'b1;
        send_psum(1000, ok);
        send_psum(2000, ok);
        // A psum presented together with clear must be dropped.
        clear = 1'b1;
        psum_valid = 1'b1;
        psum_in = ACC_BIT'(5000);
        tick();
        clear = 1'b0;
        psum_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL clear_state: got busy=%0b valid=%0b, required 0 0", busy, out_valid);
        else pass_cnt++;
        send_group(512, 256, 0, 0, 16'd5);
        wait_drain("clear");
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        out_ready = 1'b1;
        send_psum(3000, ok);
        send_psum(4000, ok);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({psum_ready, out_valid, busy, sat_flag} !== 4'b0000 || out_data !== '0)
            $display("FAIL rst_mid_acc: got ready=%0b valid=%0b busy=%0b sat=%0b data=%0d, required all 0",
                     psum_ready, out_valid, busy, sat_flag, out_data);
        else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_group(256, 512, 768, 1024, 16'd10);
        wait_drain("rst_acc_after");
        out_ready = 1'b0;
        send_group(7680, 0, 0, 0, 16'd30);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'd30)
            $display("FAIL rst_fifo_prefill: got valid=%0b data=%0d, required 1 30", out_valid, out_data);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0)
            $display("FAIL rst_fifo_flush: got valid=%0b data=%0d busy=%0b, required 0 0 0", out_valid, out_data, busy);
        else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        send_group(384, 0, 0, 0, 16'd2);
        wait_drain("rst_fifo_after");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_negative();
        test_saturation();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
